wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the MEM/WB stage output and an auxiliary multi-cycle requester, such as a divider or multiplier completing out of band.
- WB always wins the port unless starvation forces a one-cycle pipeline stall.
- Auxiliary results are buffered in a small FIFO. Queued entries are killed when a younger WB write targets the same register.
- Exports a pending-register mask for hazard detection.

Parameters:
- DEPTH, 2, aux result queue depth; power of two, ≥2
- MAX_WAIT, 4, consecutive cycles the queue head may lose arbitration before a forced grant; ≥1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- Write_Enable_WB  in  1  WB stage write request
- rd_WB  in  4  WB destination register
- wb_data  in  16  WB write data (already muxed Mem_Out/Result)
- aux_valid  in  1  aux result valid
- aux_rd  in  4  aux destination register
- aux_data  in  16  aux result
- aux_ready  out  1  queue can accept an aux result
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  register-file write address
- rf_wdata  out  16  register-file write data
- stall_pipe  out  1  pipeline must hold all stages this cycle
- pending_mask  out  16  bit r set when a valid queued entry targets register r
- aux_grant  out  1  queue head written this cycle (debug/perf)

Behaviour:
- One clock, clk. Reset is synchronous, active-high, sampled on posedge clk.
- Reset clears:
  - the queue (count=0, pointers=0, all valid bits=0)
  - wait_cnt=0
- After reset: aux_ready=1, rf_we=0, stall_pipe=0, pending_mask=0, aux_grant=0.
- While reset is high, rf_we, stall_pipe and aux_grant are forced to 0.
- Reset mid-operation discards all queued entries without writing them.
- Write-port outputs are combinational (zero latency). Queue, counters and valid bits update on posedge clk.
- Queue entry fields: {valid, rd[3:0], data[15:0]}.
- aux_ready = (count != DEPTH).
  - Handshake occurs when aux_valid && aux_ready; the entry is pushed at the clock edge.
  - aux_valid with aux_ready=0 must be held by the requester; nothing is lost.
- Definitions:
  - wb_go = Write_Enable_WB && !stall_pipe
  - head = entry at the read pointer; head_live = count!=0 && head.valid
- Grant priority, per cycle:
  1. stall_pipe=1 → head written (rf_we=1, rf_waddr=head.rd, rf_wdata=head.data, aux_grant=1), head popped. The WB request is ignored; the pipeline re-presents it next cycle.
  2. wb_go → rf_we=1, rf_waddr=rd_WB, rf_wdata=wb_data.
  3. head_live → head written and popped, aux_grant=1.
  4. Otherwise rf_we=0. rf_waddr/rf_wdata are don't-care; drive 0.
- Dead head: count!=0 with head.valid=0 is popped in any cycle with no write issued and does not consume the port. wait_cnt resets.
- Starvation:
  - wait_cnt increments each cycle head_live is true and the head is not popped.
  - wait_cnt clears on pop or when count==0.
  - stall_pipe = head_live && (wait_cnt == MAX_WAIT). It is high for exactly one cycle per forced grant.
- Kill rule (aux results are always older than concurrent WB writes):
  - When wb_go with rd_WB=X, every queued entry with rd==X has valid cleared at the edge.
  - An aux entry pushed in the same cycle with aux_rd==X is stored with valid=0. The handshake still completes.
- Simultaneous push and pop: count unchanged, pointers both advance. A push while full is impossible because aux_ready=0.
- Pointers wrap modulo DEPTH.
- count width is clog2(DEPTH)+1.
- pending_mask = OR over valid entries of one-hot(rd). It reflects the registered state, not the same-cycle push or kill.

Test Plan:
- Reset, then idle → aux_ready=1, rf_we=0, pending_mask=0x0000. Write_Enable_WB=1, rd_WB=3, wb_data=0x1234 → same cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234.
- Queue empty, WB idle; push aux rd=5 data=0xBEEF → pending_mask=0x0020 next cycle; same cycle rf_we=1, rf_waddr=5, rf_wdata=0xBEEF, aux_grant=1; following cycle pending_mask=0.
- WB writing continuously; push rd=7 data=0x00AA → head waits; wait_cnt reaches 4; stall_pipe=1 for exactly one cycle with rf_waddr=7, rf_wdata=0x00AA; next cycle stall_pipe=0 and WB resumes.
- Push rd=2 and rd=9 while WB busy (DEPTH=2) → aux_ready=0; third aux_valid held until a pop, then accepted the cycle after aux_ready=1; all three writes appear in push order.
- Queue holds rd=4 data=0x1111; WB writes rd=4 data=0x2222 → pending_mask bit4 clears; queued entry is never written; final written value of r4 is 0x2222.
- Queue holds two entries; assert reset for one cycle → count=0, pending_mask=0, aux_ready=1; no aux write ever issues for the discarded entries.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the WB stage has priority, and auxiliary results wait in a small FIFO.
// A queued entry is killed when a younger WB write targets the same register. A starving head forces a one-cycle stall.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Write_Enable_WB,
  input  logic [3:0]  rd_WB,
  input  logic [15:0] wb_data,
  input  logic        aux_valid,
  input  logic [3:0]  aux_rd,
  input  logic [15:0] aux_data,
  output logic        aux_ready,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        stall_pipe,
  output logic [15:0] pending_mask,
  output logic        aux_grant
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [DEPTH-1:0] q_valid_r;
  logic [3:0]       q_rd_r   [DEPTH];
  logic [15:0]      q_data_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [WW-1:0]    wait_cnt_r;

  logic head_live_s;
  logic wb_go_s;
  logic push_s;
  logic pop_s;
  logic stall_s;

  function automatic logic [15:0] reg_onehot(input logic [3:0] r);
    return 16'h0001 << r;
  endfunction

  assign head_live_s = (count_r != {CW{1'b0}}) && q_valid_r[rd_ptr_r];
  assign stall_s     = !reset && head_live_s && (wait_cnt_r == WW'(MAX_WAIT));
  assign wb_go_s     = Write_Enable_WB && !stall_s;
  assign aux_ready   = (count_r != CW'(DEPTH));
  assign push_s      = aux_valid && aux_ready;
  assign stall_pipe  = stall_s;

  // Write-port grant: forced head, then WB, then live head; a dead head drains on an idle port.
  always_comb begin
    rf_we     = 1'b0;
    rf_waddr  = 4'd0;
    rf_wdata  = 16'd0;
    aux_grant = 1'b0;
    pop_s     = 1'b0;
    if (reset) begin
      pop_s = 1'b0;
    end else if (stall_s) begin
      rf_we     = 1'b1;
      rf_waddr  = q_rd_r[rd_ptr_r];
      rf_wdata  = q_data_r[rd_ptr_r];
      aux_grant = 1'b1;
      pop_s     = 1'b1;
    end else if (wb_go_s) begin
      rf_we    = 1'b1;
      rf_waddr = rd_WB;
      rf_wdata = wb_data;
    end else if (head_live_s) begin
      rf_we     = 1'b1;
      rf_waddr  = q_rd_r[rd_ptr_r];
      rf_wdata  = q_data_r[rd_ptr_r];
      aux_grant = 1'b1;
      pop_s     = 1'b1;
    end else if (count_r != {CW{1'b0}}) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Pending-register mask built from the registered queue contents only.
  always_comb begin
    pending_mask = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid_r[AW'(i)]) begin
        pending_mask = pending_mask | reg_onehot(q_rd_r[AW'(i)]);
      end else begin
        pending_mask = pending_mask;
      end
    end
  end

  // Queue storage, pointers, occupancy and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid_r  <= {DEPTH{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      wait_cnt_r <= {WW{1'b0}};
    end else begin
      if (pop_s) begin
        q_valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r            <= rd_ptr_r + AW'(1);
      end
      // A WB write is younger than every queued result, so matching entries are dead.
      if (wb_go_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_rd_r[AW'(i)] == rd_WB) begin
            q_valid_r[AW'(i)] <= 1'b0;
          end
        end
      end
      if (push_s) begin
        q_valid_r[wr_ptr_r] <= !(wb_go_s && (aux_rd == rd_WB));
        q_rd_r[wr_ptr_r]    <= aux_rd;
        q_data_r[wr_ptr_r]  <= aux_data;
        wr_ptr_r            <= wr_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (pop_s || (count_r == {CW{1'b0}})) begin
        wait_cnt_r <= {WW{1'b0}};
      end else if (head_live_s) begin
        wait_cnt_r <= wait_cnt_r + WW'(1);
      end
    end
  end

endmodule
